// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine: optional identity fill, then the 256-step swap loop
// over an external single-port 256x8 RAM with a build-time read latency.
module rc4_ksa_engine #(
  parameter int MAX_KEY_BYTES = 16,
  parameter int RD_LATENCY    = 2,
  parameter int KL_W          = $clog2(MAX_KEY_BYTES + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       do_init,
  input  logic [KL_W-1:0]            key_len,
  input  logic [8*MAX_KEY_BYTES-1:0] key,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 addr,
  input  logic [7:0]                 rddata,
  output logic [7:0]                 wrdata,
  output logic                       wren,
  output logic [3:0]                 dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_INIT_WR = 4'd1,
    S_RD_I    = 4'd2,
    S_WAIT_I  = 4'd3,
    S_RD_J    = 4'd4,
    S_WAIT_J  = 4'd5,
    S_WR_J    = 4'd6,
    S_WR_I    = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  localparam int              KW        = 8 * MAX_KEY_BYTES;
  localparam logic [KL_W-1:0] KL_MAX    = KL_W'(MAX_KEY_BYTES);
  localparam logic [2:0]      WAIT_LAST = 3'(RD_LATENCY - 1);

  state_t          state_q, state_d;
  logic [7:0]      i_q, i_d;
  logic [7:0]      j_q, j_d;
  logic [7:0]      si_q, si_d;
  logic [7:0]      sj_q, sj_d;
  logic [KL_W-1:0] kidx_q, kidx_d;
  logic [KL_W-1:0] klen_q, klen_d;
  logic [KW-1:0]   key_q, key_d;
  logic [2:0]      wcnt_q, wcnt_d;
  logic [7:0]      key_byte;
  logic [KL_W-1:0] kidx_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      kidx_q  <= '0;
      klen_q  <= '0;
      key_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      kidx_q  <= kidx_d;
      klen_q  <= klen_d;
      key_q   <= key_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Byte 0 is the most significant byte of the latched key.
  always_comb begin
    key_byte = '0;
    for (int k = 0; k < MAX_KEY_BYTES; k++) begin
      if (kidx_q == KL_W'(k)) key_byte = key_q[KW-1-8*k -: 8];
    end
  end

  assign kidx_inc  = kidx_q + KL_W'(1);
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    kidx_d  = kidx_q;
    klen_d  = klen_q;
    key_d   = key_q;
    wcnt_d  = wcnt_q;
    busy    = (state_q != S_IDLE);
    done    = 1'b0;
    addr    = '0;
    wrdata  = '0;
    wren    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          key_d   = key;
          klen_d  = ((key_len == '0) || (key_len > KL_MAX)) ? KL_MAX : key_len;
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          state_d = do_init ? S_INIT_WR : S_RD_I;
        end
      end
      S_INIT_WR: begin
        wren   = 1'b1;
        addr   = i_q;
        wrdata = i_q;
        i_d    = i_q + 8'd1;
        if (i_q == 8'hFF) state_d = S_RD_I;
      end
      S_RD_I: begin
        addr    = i_q;
        wcnt_d  = '0;
        state_d = S_WAIT_I;
      end
      S_WAIT_I: begin
        addr = i_q;
        if (wcnt_q == WAIT_LAST) begin
          si_d    = rddata;
          j_d     = j_q + rddata + key_byte;
          kidx_d  = (kidx_inc == klen_q) ? '0 : kidx_inc;
          state_d = S_RD_J;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      S_RD_J: begin
        addr    = j_q;
        wcnt_d  = '0;
        state_d = S_WAIT_J;
      end
      S_WAIT_J: begin
        addr = j_q;
        if (wcnt_q == WAIT_LAST) begin
          sj_d    = rddata;
          state_d = S_WR_J;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      S_WR_J: begin
        wren    = 1'b1;
        addr    = j_q;
        wrdata  = si_q;
        state_d = S_WR_I;
      end
      // When i == j both writes hit one address with the same value.
      S_WR_I: begin
        wren    = 1'b1;
        addr    = i_q;
        wrdata  = sj_q;
        i_d     = i_q + 8'd1;
        state_d = (i_q == 8'hFF) ? S_DONE : S_RD_I;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Bench for rc4_ksa_engine: behavioural RAMs with read latency, a reference KSA
// scoreboard checked on every done pulse, and directed run scenarios.
module tb_rc4_ksa_engine;

  localparam int KLW = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic start0, start1, do_init;
  logic [KLW-1:0] key_len;
  logic [127:0] key;

  logic busy0, done0, wren0, busy1, done1, wren1;
  logic [7:0] addr0, wrdata0, rddata0, addr1, wrdata1, rddata1;
  logic [3:0] dbg0, dbg1;

  logic [7:0] mem0[256];
  logic [7:0] mem1[256];
  logic [7:0] ap0[2];
  logic [7:0] ap1;
  logic preload0;
  int   wr_cnt0;
  logic [15:0] w_a, w_b;

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  int n_vec = 0;
  int n_fail = 0;
  int cyc0 = 0, cyc1 = 0, viol0 = 0, viol1 = 0;
  logic [7:0] prev_a0, prev_a1;

  always #5 clk = ~clk;

  rc4_ksa_engine #(.MAX_KEY_BYTES(16), .RD_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .do_init(do_init), .key_len(key_len),
    .key(key), .busy(busy0), .done(done0), .addr(addr0), .rddata(rddata0),
    .wrdata(wrdata0), .wren(wren0), .dbg_state(dbg0)
  );

  rc4_ksa_engine #(.MAX_KEY_BYTES(16), .RD_LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .do_init(do_init), .key_len(key_len),
    .key(key), .busy(busy1), .done(done1), .addr(addr1), .rddata(rddata1),
    .wrdata(wrdata1), .wren(wren1), .dbg_state(dbg1)
  );

  // RAM models: address pipelined RD_LATENCY edges, data read from the array.
  assign rddata0 = mem0[ap0[1]];
  assign rddata1 = mem1[ap1];

  always @(posedge clk) begin
    ap0[0] <= addr0;
    ap0[1] <= ap0[0];
    if (preload0) begin
      for (int k = 0; k < 256; k++) mem0[k] <= 8'(k);
    end else if (wren0) begin
      mem0[addr0] <= wrdata0;
    end
    if (start0 && !busy0) begin
      wr_cnt0 <= 0;
    end else if (wren0) begin
      if (wr_cnt0 == 256) w_a <= {addr0, wrdata0};
      if (wr_cnt0 == 257) w_b <= {addr0, wrdata0};
      wr_cnt0 <= wr_cnt0 + 1;
    end
  end

  always @(posedge clk) begin
    ap1 <= addr1;
    if (wren1) mem1[addr1] <= wrdata1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference KSA from the identity permutation; pushes cycle count then S-box.
  task automatic push_expect(input int which, input logic [127:0] k, input int kl,
                             input bit init, input int lat);
    logic [7:0] s[256];
    logic [7:0] j, t, kb;
    int n, cyc;
    n = (kl == 0 || kl > 16) ? 16 : kl;
    for (int x = 0; x < 256; x++) s[x] = 8'(x);
    j = 8'd0;
    for (int x = 0; x < 256; x++) begin
      kb = 8'(k >> (8 * (15 - (x % n))));
      j = j + s[x] + kb;
      t = s[x];
      s[x] = s[j];
      s[j] = t;
    end
    cyc = (init ? 256 : 0) + 256 * (2 * lat + 4) + 1;
    if (which == 0) begin
      exp_q0.push_back(16'(cyc));
      for (int x = 0; x < 256; x++) exp_q0.push_back({8'h00, s[x]});
    end else begin
      exp_q1.push_back(16'(cyc));
      for (int x = 0; x < 256; x++) exp_q1.push_back({8'h00, s[x]});
    end
  endtask

  // Monitors: count busy cycles, police read windows, compare on done.
  always @(negedge clk) begin
    if (!rst_n) begin
      cyc0 = 0;
    end else begin
      if (busy0) cyc0++;
      if ((dbg0 inside {4'd2, 4'd3, 4'd4, 4'd5}) && wren0) viol0++;
      if ((dbg0 == 4'd3 || dbg0 == 4'd5) && addr0 != prev_a0) viol0++;
      if (done0) begin
        if (exp_q0.size() < 257) begin
          check("dut0_unexpected_done", 32'(exp_q0.size()), 32'd257);
        end else begin
          check("dut0_cycles", 32'(cyc0), 32'(exp_q0.pop_front()));
          for (int x = 0; x < 256; x++)
            check($sformatf("dut0_ram[%0d]", x), 32'(mem0[x]), 32'(exp_q0.pop_front()));
        end
        cyc0 = 0;
      end
    end
    prev_a0 = addr0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      cyc1 = 0;
    end else begin
      if (busy1) cyc1++;
      if ((dbg1 inside {4'd2, 4'd3, 4'd4, 4'd5}) && wren1) viol1++;
      if ((dbg1 == 4'd3 || dbg1 == 4'd5) && addr1 != prev_a1) viol1++;
      if (done1) begin
        if (exp_q1.size() < 257) begin
          check("dut1_unexpected_done", 32'(exp_q1.size()), 32'd257);
        end else begin
          check("dut1_cycles", 32'(cyc1), 32'(exp_q1.pop_front()));
          for (int x = 0; x < 256; x++)
            check($sformatf("dut1_ram[%0d]", x), 32'(mem1[x]), 32'(exp_q1.pop_front()));
        end
        cyc1 = 0;
      end
    end
    prev_a1 = addr1;
  end

  task automatic kick(input int which, input bit init, input int kl, input logic [127:0] k,
                      input bit push);
    if (push) push_expect(which, k, kl, init, (which == 0) ? 2 : 1);
    do_init = init;
    key_len = KLW'(kl);
    key     = k;
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input int which, input string name);
    int c = 0;
    while (((which == 0) ? exp_q0.size() : exp_q1.size()) != 0 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    check({name, "_drained"}, 32'((which == 0) ? exp_q0.size() : exp_q1.size()), 32'd0);
    if (which == 0) exp_q0.delete(); else exp_q1.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"},   32'(busy0),   32'd0);
    check({name, "_done"},   32'(done0),   32'd0);
    check({name, "_wren"},   32'(wren0),   32'd0);
    check({name, "_addr"},   32'(addr0),   32'd0);
    check({name, "_wrdata"}, 32'(wrdata0), 32'd0);
    check({name, "_state"},  32'(dbg0),    32'd0);
  endtask

  initial begin
    logic [127:0] rk;
    int c;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; do_init = 1'b0;
    key_len = '0; key = '0; preload0 = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Key 00 03 3C with identity fill: 2305-cycle run.
    kick(0, 1'b1, 3, {8'h00, 8'h03, 8'h3C, 104'h0}, 1'b1);
    wait_done(0, "t1");

    // Single zero key byte: first swap is addr0<-0 twice.
    kick(0, 1'b1, 1, 128'h0, 1'b1);
    wait_done(0, "t2");
    check("t2_wr_j0", 32'(w_a), 32'h0000);
    check("t2_wr_i0", 32'(w_b), 32'h0000);

    // Identity preloaded, no fill, random 16-byte key: 2049-cycle run.
    preload0 = 1'b1;
    @(negedge clk);
    preload0 = 1'b0;
    rk = {$urandom(), $urandom(), $urandom(), $urandom()};
    kick(0, 1'b0, 16, rk, 1'b1);
    wait_done(0, "t3");

    // Restart attempt and input changes mid-run must be ignored.
    kick(0, 1'b1, 5, 128'hA5_5A_01_FE_77_000000000000000000000, 1'b1);
    repeat (600) @(negedge clk);
    key = ~key; key_len = 5'd2; do_init = 1'b0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done(0, "t4");

    // Reset during iteration i=100, then a clean run with key 01 02 03.
    kick(0, 1'b1, 3, {8'h11, 8'h22, 8'h33, 104'h0}, 1'b0);
    c = 0;
    while (wr_cnt0 < 456 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check("t5_reached_i100", 32'(wr_cnt0), 32'd456);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t5_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    kick(0, 1'b1, 3, {8'h01, 8'h02, 8'h03, 104'h0}, 1'b1);
    wait_done(0, "t5");

    // Latency-1 build, key_len 0 clamps to 16: 1793-cycle run.
    rk = {$urandom(), $urandom(), $urandom(), $urandom()};
    kick(1, 1'b1, 0, rk, 1'b1);
    wait_done(1, "t6");

    check("dut0_read_window", 32'(viol0), 32'd0);
    check("dut1_read_window", 32'(viol1), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/rc4_ksa_engine.md
# rc4_ksa_engine

Parametrised RC4 key-scheduling engine that owns one 256x8 single-port state RAM (S-box) during a run. On a `start` pulse it optionally performs the identity fill (S[i]=i), then runs the full swap loop: j = j + S[i] + key[i mod key_len], swap S[i] and S[j]. Key length is selectable at run time, and memory read latency is a build parameter. It sits between the key source (switches or key-search counter) and the decrypt stage, which waits for `done`.

## Interface
- `MAX_KEY_BYTES`, default 16: maximum key length in bytes; key port width is 8*MAX_KEY_BYTES.
- `RD_LATENCY`, default 2: cycles from `addr` presented (wren=0) to `rddata` valid; legal range 1..4.
- `KL_W`, default $clog2(MAX_KEY_BYTES+1): width of `key_len`.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `do_init`  in  1  latched at start; 1 = identity fill before the swap loop.
- `key_len`  in  KL_W  key length in bytes; latched at start.
- `key`  in  8*MAX_KEY_BYTES  key bytes; byte k = key[8*MAX_KEY_BYTES-1-8k -: 8] (byte 0 is the MSB byte); latched at start.
- `busy`  out  1  high from the cycle after accepted start until the done cycle inclusive.
- `done`  out  1  one-cycle pulse at completion.
- `addr`  out  8  RAM address.
- `rddata`  in  8  RAM read data.
- `wrdata`  out  8  RAM write data.
- `wren`  out  1  RAM write enable.

## Operation
- States: IDLE, INIT_WR, RD_I, WAIT_I, RD_J, WAIT_J, WR_J, WR_I, DONE.
- IDLE: if start=1, latch key, key_len and do_init, then i=0, j=0, kidx=0, and go to INIT_WR (do_init=1) or RD_I (do_init=0).
- key_len of 0, or greater than MAX_KEY_BYTES, is clamped to MAX_KEY_BYTES at latch time.
- INIT_WR: wren=1, addr=i, wrdata=i. Repeat for i=0..255, then i=0 and go to RD_I.
- RD_I: addr=i, wren=0. WAIT_I holds RD_LATENCY-1 cycles, then captures si=rddata.
- On capture: j = (j + si + key_byte[kidx]) mod 256, using the current key byte with no extra register stage. kidx wraps to 0 when kidx+1 equals the latched key_len; no divider is used.
- RD_J: addr=j (new value), wren=0. WAIT_J captures sj after the same latency.
- WR_J: wren=1, addr=j, wrdata=si.
- WR_I: wren=1, addr=i, wrdata=sj. If i=255 go to DONE, otherwise i=i+1 and go to RD_I.
- i==j: both writes target the same address with the same value; no special case is needed.
- DONE: done=1 and wren=0 for one cycle, then IDLE. Outputs return to reset values; S-box contents are left in RAM.
- start while busy is ignored. Changes to key, key_len or do_init during a run have no effect.
- Arithmetic: i, j, si and sj are 8-bit and wrap mod 256 naturally.

## Timing
- Reset values: addr=0, wrdata=0, wren=0, busy=0, done=0; state=IDLE; i=j=kidx=0.
- Reset mid-run returns immediately to IDLE. The RAM is left partially permuted; the next start with do_init=1 yields a correct result.
- Cycle s: start sampled in IDLE. Cycle s+1: busy=1 and the first INIT_WR or RD_I is active.
- Init phase: exactly 256 cycles, one write per cycle.
- Swap iteration: 2*(1+RD_LATENCY)+2 cycles, which is 8 cycles for RD_LATENCY=2.
- Total from s+1 to the done cycle inclusive: 256*do_init + 256*(2*RD_LATENCY+4) + 1.
- wren is never high during RD_I, WAIT_I, RD_J or WAIT_J.
- addr is stable for the whole read-wait window.

## Test plan
- RD_LATENCY=2, do_init=1, key_len=3, key bytes 00 03 3C: final RAM matches the software RC4 KSA model byte-for-byte. done pulses exactly 2305 cycles after s+1 is entered; busy is high for that whole window.
- key_len=1, key byte 00, first iteration: si=0 and j=0, so writes addr0←0 then addr0←0. Final RAM matches the model.
- Preload the RAM with the identity permutation, do_init=0, key_len=16, random key: the result matches the model. done arrives 2049 cycles after s+1.
- Pulse start again mid-run and change key and key_len mid-run: no restart, and the final result equals the originally latched key's model.
- Assert rst_n=0 during iteration i=100: all outputs are 0 in the same cycle and state is IDLE. Then start with do_init=1, key 01 02 03: the result matches the model.
- Build with RD_LATENCY=1 and apply key_len=0 with a 16-byte key: treated as 16 bytes, matches the model, and total is 256+256*6+1 cycles.
